debug_cmd_decoder: RTL and testbench
====================================

Name: debug_cmd_decoder

Overview:
- Front end of the MicroBlaze-to-MIPS debug link.
- Registers the 32-bit control frame sent by the MicroBlaze and detects each new command on the rising edge of the frame's valid bit.
- Decodes commands into one-cycle strobes, run-control levels and instruction-memory writes for the pipeline and the latch-readout controllers.
- Sits between the AXI/GPIO frame register and the pipeline core.

Parameters:
- NB_CONTROL_FRAME, 32, frame width.
- NB_CMD, 6, command code width.
- NB_ADDR_TYPE, 9, address-type field width.
- NB_ADDR_DATA, 16, address/data field width.
- NB_INSTR, 32, instruction word width.
- NB_INSTR_ADDR, 9, instruction memory address width (N_ADDR=512).

Ports:
- i_clock  in  1  system clock.
- i_reset  in  1  asynchronous, active-low reset.
- i_frame_from_blaze  in  NB_CONTROL_FRAME  {code[31:26], valid[25], type[24:16], data[15:0]}.
- i_program_end  in  1  level from pipeline; program reached end.
- o_pipe_enable  out  1  pipeline advance enable.
- o_pipe_reset  out  1  one-cycle pipeline soft-reset strobe.
- o_mode_step  out  1  1 = step mode, 0 = continuous.
- o_instr_we  out  1  instruction memory write strobe.
- o_instr_addr  out  NB_INSTR_ADDR  write address.
- o_instr_data  out  NB_INSTR  write data.
- o_req_valid  out  1  data-request strobe to readout mux.
- o_req_type  out  NB_ADDR_TYPE  requested source.
- o_req_addr  out  NB_ADDR_DATA  requested index.
- o_got_data  out  1  strobe: MicroBlaze consumed a word.
- o_gib_data  out  1  strobe: MicroBlaze wants the next word.
- o_state  out  2  00 IDLE, 01 RUN, 10 DONE.
- o_error  out  1  one-cycle illegal/unknown command strobe.

Behaviour:
- **Reset (i_reset=0):**
  - All outputs 0, state IDLE, o_mode_step=0.
  - LSB buffer cleared and pending flag cleared.
  - Internal frame register and previous-valid bit cleared.
- **Capture:** each clock the frame is registered into r_frame, and r_valid_d holds the previous r_frame valid bit.
  - A command is accepted when r_frame.valid=1 and r_valid_d=0.
  - Holding valid high for N cycles yields exactly one command.
- **Latency:** all outputs are registered.
  - Valid first sampled high at edge k → strobe/level change visible after edge k+2.
  - Every strobe is exactly one cycle wide.
- **Command codes:**
  - START 000001:
    - IDLE → RUN.
    - In RUN or DONE: o_error, no state change.
  - RESET 000010:
    - Any state → IDLE.
    - o_pipe_reset pulse; LSB pending cleared; o_mode_step retained.
  - MODE_SET_CONT 001001 / MODE_SET_STEP 001010:
    - IDLE only: o_mode_step ← 0 / 1.
    - Otherwise o_error.
  - MODE_GET 001000:
    - o_req_valid with o_req_type=9'h000, o_req_addr={15'b0, o_mode_step}.
  - LOAD_INSTR_LSB 000100:
    - IDLE only.
    - lsb ← data, lsb_addr ← type[8:0], pending ← 1.
  - LOAD_INSTR_MSB 000101, IDLE only:
    - If pending and type[8:0]==lsb_addr: o_instr_we pulse, o_instr_data={data, lsb}, o_instr_addr=lsb_addr, pending ← 0.
    - Else: o_error, no write.
  - STEP 100000:
    - RUN and o_mode_step=1: o_pipe_enable high for exactly one cycle.
    - Otherwise ignored, no error.
  - REQ_DATA 000011:
    - o_req_valid pulse with o_req_type=type, o_req_addr=data.
    - Legal in all states.
  - GOT_DATA 100100 / GIB_DATA 100101:
    - o_got_data / o_gib_data pulse.
    - Legal in all states.
  - Any other code: o_error.
  - Any load or mode-set command outside IDLE: o_error.
- **o_pipe_enable:**
  - Level 1 while state=RUN and o_mode_step=0.
  - In step mode, only the STEP pulse drives it.
  - Always 0 in IDLE and DONE.
- **Program end:**
  - i_program_end=1 while in RUN → DONE on the next edge.
  - o_pipe_enable drops in the same cycle the state changes.
  - If a STEP is accepted on the same edge, DONE wins and no enable pulse is issued.
- **DONE:** only RESET leaves it.
- **Simultaneous events:**
  - RESET accepted on the same edge as i_program_end → IDLE.
  - Asynchronous reset mid-command discards the command.
  - After reset release, a frame whose valid is already high is accepted once, since r_valid_d resets to 0.

Test Plan:
- **Edge detect:** reset, then hold frame {START, valid=1} for 3 cycles → state IDLE→RUN once, o_pipe_enable=1 two edges after first valid sample, no o_error.
- **Instruction load:** in IDLE send LSB (type=9'd5, data=16'h0020), drop valid, then MSB (type=9'd5, data=16'h2408) → single o_instr_we, addr=5, data=32'h24080020. MSB alone with type=9'd6 → o_error, no write.
- **Step mode:**
  - Send MODE_SET_STEP, START, then three STEP commands → exactly three one-cycle o_pipe_enable pulses.
  - Send MODE_SET_CONT while in RUN → o_error, o_mode_step stays 1.
- **Program end and RESET:**
  - In RUN continuous, raise i_program_end → state DONE, enable 0.
  - START → o_error.
  - RESET → IDLE plus one o_pipe_reset pulse.
- **Readout handshake:**
  - REQ_DATA type=9'h002 addr=0 → o_req_valid with those values.
  - GOT_DATA and GIB_DATA (type=9'h010, addr=1), each held 3 cycles → one o_got_data pulse and one o_gib_data pulse respectively.
  - Unknown code 111111 → o_error.
- **Async reset:**
  - Pull i_reset low mid-RUN between clock edges → all outputs 0 immediately.
  - Release with valid still high on a START frame → START accepted once, state RUN.

Source files
------------

// File: rtl/debug_cmd_decoder.sv
// Debug-link command front end: registers the MicroBlaze control frame, detects new
// commands on the valid rising edge and turns them into registered strobes and levels.
module debug_cmd_decoder #(
    parameter int NB_CONTROL_FRAME = 32,
    parameter int NB_CMD           = 6,
    parameter int NB_ADDR_TYPE     = 9,
    parameter int NB_ADDR_DATA     = 16,
    parameter int NB_INSTR         = 32,
    parameter int NB_INSTR_ADDR    = 9
) (
    input  logic                        i_clock,
    input  logic                        i_reset,
    input  logic [NB_CONTROL_FRAME-1:0] i_frame_from_blaze,
    input  logic                        i_program_end,
    output logic                        o_pipe_enable,
    output logic                        o_pipe_reset,
    output logic                        o_mode_step,
    output logic                        o_instr_we,
    output logic [NB_INSTR_ADDR-1:0]    o_instr_addr,
    output logic [NB_INSTR-1:0]         o_instr_data,
    output logic                        o_req_valid,
    output logic [NB_ADDR_TYPE-1:0]     o_req_type,
    output logic [NB_ADDR_DATA-1:0]     o_req_addr,
    output logic                        o_got_data,
    output logic                        o_gib_data,
    output logic [1:0]                  o_state,
    output logic                        o_error
);

    localparam int VALID_BIT = NB_ADDR_TYPE + NB_ADDR_DATA;

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_RUN  = 2'b01;
    localparam logic [1:0] ST_DONE = 2'b10;

    localparam logic [NB_CMD-1:0] CMD_START     = 6'b000001;
    localparam logic [NB_CMD-1:0] CMD_RESET     = 6'b000010;
    localparam logic [NB_CMD-1:0] CMD_REQ_DATA  = 6'b000011;
    localparam logic [NB_CMD-1:0] CMD_LOAD_LSB  = 6'b000100;
    localparam logic [NB_CMD-1:0] CMD_LOAD_MSB  = 6'b000101;
    localparam logic [NB_CMD-1:0] CMD_MODE_GET  = 6'b001000;
    localparam logic [NB_CMD-1:0] CMD_MODE_CONT = 6'b001001;
    localparam logic [NB_CMD-1:0] CMD_MODE_STEP = 6'b001010;
    localparam logic [NB_CMD-1:0] CMD_STEP      = 6'b100000;
    localparam logic [NB_CMD-1:0] CMD_GOT_DATA  = 6'b100100;
    localparam logic [NB_CMD-1:0] CMD_GIB_DATA  = 6'b100101;

    logic [NB_CONTROL_FRAME-1:0] frame_q;
    logic                        valid_prev_q;

    logic                        cmd_vld_q;
    logic [NB_CMD-1:0]           cmd_code_q;
    logic [NB_ADDR_TYPE-1:0]     cmd_type_q;
    logic [NB_ADDR_DATA-1:0]     cmd_data_q;

    logic [1:0]                  state_q, state_d;
    logic                        mode_q, mode_d;
    logic                        en_q, en_d;
    logic                        prst_q, prst_d;
    logic                        we_q, we_d;
    logic [NB_INSTR_ADDR-1:0]    iaddr_q, iaddr_d;
    logic [NB_INSTR-1:0]         idata_q, idata_d;
    logic                        rv_q, rv_d;
    logic [NB_ADDR_TYPE-1:0]     rtype_q, rtype_d;
    logic [NB_ADDR_DATA-1:0]     raddr_q, raddr_d;
    logic                        got_q, got_d;
    logic                        gib_q, gib_d;
    logic                        err_q, err_d;
    logic [NB_ADDR_DATA-1:0]     lsb_q, lsb_d;
    logic [NB_INSTR_ADDR-1:0]    lsb_addr_q, lsb_addr_d;
    logic                        pend_q, pend_d;
    logic                        step_d;
    logic                        reset_cmd;

    // Capture and decode stages: a command exists only on the first cycle valid is seen high.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            frame_q      <= '0;
            valid_prev_q <= 1'b0;
            cmd_vld_q    <= 1'b0;
            cmd_code_q   <= '0;
            cmd_type_q   <= '0;
            cmd_data_q   <= '0;
        end else begin
            frame_q      <= i_frame_from_blaze;
            valid_prev_q <= frame_q[VALID_BIT];
            cmd_vld_q    <= frame_q[VALID_BIT] & ~valid_prev_q;
            cmd_code_q   <= frame_q[NB_CONTROL_FRAME-1 -: NB_CMD];
            cmd_type_q   <= frame_q[NB_ADDR_DATA +: NB_ADDR_TYPE];
            cmd_data_q   <= frame_q[NB_ADDR_DATA-1:0];
        end
    end

    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        pend_d     = pend_q;
        lsb_d      = lsb_q;
        lsb_addr_d = lsb_addr_q;
        iaddr_d    = iaddr_q;
        idata_d    = idata_q;
        rtype_d    = rtype_q;
        raddr_d    = raddr_q;
        prst_d     = 1'b0;
        we_d       = 1'b0;
        rv_d       = 1'b0;
        got_d      = 1'b0;
        gib_d      = 1'b0;
        err_d      = 1'b0;
        step_d     = 1'b0;
        reset_cmd  = 1'b0;
        if (cmd_vld_q) begin
            case (cmd_code_q)
                CMD_START: begin
                    if (state_q == ST_IDLE) state_d = ST_RUN;
                    else                    err_d   = 1'b1;
                end
                CMD_RESET: begin
                    state_d   = ST_IDLE;
                    prst_d    = 1'b1;
                    pend_d    = 1'b0;
                    reset_cmd = 1'b1;
                end
                CMD_MODE_CONT, CMD_MODE_STEP: begin
                    if (state_q == ST_IDLE) mode_d = (cmd_code_q == CMD_MODE_STEP);
                    else                    err_d  = 1'b1;
                end
                CMD_MODE_GET: begin
                    rv_d    = 1'b1;
                    rtype_d = '0;
                    raddr_d = {{(NB_ADDR_DATA-1){1'b0}}, mode_q};
                end
                CMD_LOAD_LSB: begin
                    if (state_q == ST_IDLE) begin
                        lsb_d      = cmd_data_q;
                        lsb_addr_d = cmd_type_q[NB_INSTR_ADDR-1:0];
                        pend_d     = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                CMD_LOAD_MSB: begin
                    // The MSB half must name the same address as the buffered LSB half.
                    if (state_q == ST_IDLE && pend_q &&
                        cmd_type_q[NB_INSTR_ADDR-1:0] == lsb_addr_q) begin
                        we_d    = 1'b1;
                        iaddr_d = lsb_addr_q;
                        idata_d = {cmd_data_q, lsb_q};
                        pend_d  = 1'b0;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                CMD_STEP:     step_d = (state_q == ST_RUN) && mode_q;
                CMD_REQ_DATA: begin
                    rv_d    = 1'b1;
                    rtype_d = cmd_type_q;
                    raddr_d = cmd_data_q;
                end
                CMD_GOT_DATA: got_d = 1'b1;
                CMD_GIB_DATA: gib_d = 1'b1;
                default:      err_d = 1'b1;
            endcase
        end
        // Program end beats a concurrent STEP; only a RESET command overrides it.
        if (i_program_end && state_q == ST_RUN && !reset_cmd) state_d = ST_DONE;
        en_d = (state_d == ST_RUN) && (!mode_d || step_d);
    end

    // Output stage: every output is a register.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state_q    <= ST_IDLE;
            mode_q     <= 1'b0;
            en_q       <= 1'b0;
            prst_q     <= 1'b0;
            we_q       <= 1'b0;
            iaddr_q    <= '0;
            idata_q    <= '0;
            rv_q       <= 1'b0;
            rtype_q    <= '0;
            raddr_q    <= '0;
            got_q      <= 1'b0;
            gib_q      <= 1'b0;
            err_q      <= 1'b0;
            lsb_q      <= '0;
            lsb_addr_q <= '0;
            pend_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            en_q       <= en_d;
            prst_q     <= prst_d;
            we_q       <= we_d;
            iaddr_q    <= iaddr_d;
            idata_q    <= idata_d;
            rv_q       <= rv_d;
            rtype_q    <= rtype_d;
            raddr_q    <= raddr_d;
            got_q      <= got_d;
            gib_q      <= gib_d;
            err_q      <= err_d;
            lsb_q      <= lsb_d;
            lsb_addr_q <= lsb_addr_d;
            pend_q     <= pend_d;
        end
    end

    assign o_pipe_enable = en_q;
    assign o_pipe_reset  = prst_q;
    assign o_mode_step   = mode_q;
    assign o_instr_we    = we_q;
    assign o_instr_addr  = iaddr_q;
    assign o_instr_data  = idata_q;
    assign o_req_valid   = rv_q;
    assign o_req_type    = rtype_q;
    assign o_req_addr    = raddr_q;
    assign o_got_data    = got_q;
    assign o_gib_data    = gib_q;
    assign o_state       = state_q;
    assign o_error       = err_q;

endmodule

// File: tb/tb_debug_cmd_decoder.sv
// Scoreboard bench for debug_cmd_decoder: an event-level command model predicts each
// observable response; a monitor pops and compares whenever the DUT shows activity.
module tb_debug_cmd_decoder;

    localparam logic [5:0] C_START = 6'b000001, C_RESET = 6'b000010, C_REQ = 6'b000011;
    localparam logic [5:0] C_LSB = 6'b000100, C_MSB = 6'b000101, C_MGET = 6'b001000;
    localparam logic [5:0] C_MCONT = 6'b001001, C_MSTEP = 6'b001010, C_STEP = 6'b100000;
    localparam logic [5:0] C_GOT = 6'b100100, C_GIB = 6'b100101;
    localparam logic [1:0] S_IDLE = 2'b00, S_RUN = 2'b01, S_DONE = 2'b10;

    logic        i_clock = 1'b0;
    logic        i_reset = 1'b0;
    logic [31:0] i_frame_from_blaze = '0;
    logic        i_program_end = 1'b0;
    logic        o_pipe_enable, o_pipe_reset, o_mode_step, o_instr_we;
    logic [8:0]  o_instr_addr;
    logic [31:0] o_instr_data;
    logic        o_req_valid;
    logic [8:0]  o_req_type;
    logic [15:0] o_req_addr;
    logic        o_got_data, o_gib_data, o_error;
    logic [1:0]  o_state;

    debug_cmd_decoder dut (
        .i_clock(i_clock), .i_reset(i_reset), .i_frame_from_blaze(i_frame_from_blaze),
        .i_program_end(i_program_end), .o_pipe_enable(o_pipe_enable),
        .o_pipe_reset(o_pipe_reset), .o_mode_step(o_mode_step), .o_instr_we(o_instr_we),
        .o_instr_addr(o_instr_addr), .o_instr_data(o_instr_data), .o_req_valid(o_req_valid),
        .o_req_type(o_req_type), .o_req_addr(o_req_addr), .o_got_data(o_got_data),
        .o_gib_data(o_gib_data), .o_state(o_state), .o_error(o_error)
    );

    always #5 i_clock = ~i_clock;

    int cyc = 0;
    always @(posedge i_clock) cyc <= cyc + 1;

    typedef struct {
        int         cyc;
        logic [1:0] st;
        logic       mode, en, en_after, prst, we, rv, got, gib, err;
        logic [8:0] ia;
        logic [31:0] id;
        logic [8:0] rt;
        logic [15:0] ra;
    } rec_t;

    rec_t q[$];
    int checks = 0;
    int errors = 0;
    int en_rises = 0;

    // Reference model state
    logic [1:0]  m_st = S_IDLE;
    logic        m_mode = 1'b0;
    logic        m_pend = 1'b0;
    logic [15:0] m_lsb = '0;
    logic [8:0]  m_laddr = '0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic bit is_legal(input logic [5:0] c);
        return c inside {C_START, C_RESET, C_REQ, C_LSB, C_MSB, C_MGET, C_MCONT, C_MSTEP,
                         C_STEP, C_GOT, C_GIB};
    endfunction

    task automatic model_reset();
        m_st = S_IDLE; m_mode = 1'b0; m_pend = 1'b0; m_lsb = '0; m_laddr = '0;
    endtask

    // Apply one accepted command (and/or program-end) to the model; queue it if visible.
    task automatic model_apply(input bit has, input logic [5:0] code, input logic [8:0] typ,
                               input logic [15:0] dat, input bit pe, input int ecyc);
        rec_t r;
        logic [1:0] pst;
        logic pmode, pen, step, lvl;
        r = '{default: '0};
        pst = m_st; pmode = m_mode; pen = (m_st == S_RUN) && !m_mode;
        step = 1'b0;
        if (has) begin
            if (code == C_START) begin
                if (m_st == S_IDLE) m_st = S_RUN; else r.err = 1'b1;
            end else if (code == C_RESET) begin
                m_st = S_IDLE; r.prst = 1'b1; m_pend = 1'b0;
            end else if (code == C_MCONT || code == C_MSTEP) begin
                if (m_st == S_IDLE) m_mode = (code == C_MSTEP); else r.err = 1'b1;
            end else if (code == C_MGET) begin
                r.rv = 1'b1; r.rt = 9'h000; r.ra = {15'b0, pmode};
            end else if (code == C_LSB) begin
                if (m_st == S_IDLE) begin m_lsb = dat; m_laddr = typ; m_pend = 1'b1; end
                else r.err = 1'b1;
            end else if (code == C_MSB) begin
                if (m_st == S_IDLE && m_pend && typ == m_laddr) begin
                    r.we = 1'b1; r.ia = m_laddr; r.id = {dat, m_lsb}; m_pend = 1'b0;
                end else r.err = 1'b1;
            end else if (code == C_STEP) begin
                step = (m_st == S_RUN) && m_mode;
            end else if (code == C_REQ) begin
                r.rv = 1'b1; r.rt = typ; r.ra = dat;
            end else if (code == C_GOT) r.got = 1'b1;
            else if (code == C_GIB) r.gib = 1'b1;
            else r.err = 1'b1;
        end
        if (pe && pst == S_RUN && !(has && code == C_RESET)) m_st = S_DONE;
        if (m_st != S_RUN) step = 1'b0;
        lvl = (m_st == S_RUN) && !m_mode;
        r.en = step | lvl;
        r.en_after = lvl;
        r.st = m_st; r.mode = m_mode; r.cyc = ecyc;
        if (r.prst || r.we || r.rv || r.got || r.gib || r.err || m_st != pst ||
            m_mode != pmode || r.en != pen)
            q.push_back(r);
    endtask

    task automatic idle_frame();
        logic [31:0] f;
        f = $urandom();
        f[25] = 1'b0;
        i_frame_from_blaze = f;
    endtask

    // Issue one command; optionally raise program_end on the edge the command takes effect.
    task automatic send(input logic [5:0] code, input logic [8:0] typ, input logic [15:0] dat,
                        input int hold, input bit pe);
        int n;
        @(negedge i_clock);
        model_apply(1'b1, code, typ, dat, pe, cyc + 3);
        i_frame_from_blaze = {code, 1'b1, typ, dat};
        n = (hold > 3) ? hold : 3;
        for (int i = 1; i <= n; i++) begin
            @(negedge i_clock);
            if (i == hold) idle_frame();
            if (pe && i == 2) i_program_end = 1'b1;
            if (pe && i == 3) i_program_end = 1'b0;
        end
        repeat (2) @(negedge i_clock);
    endtask

    task automatic pulse_end();
        @(negedge i_clock);
        model_apply(1'b0, 6'd0, 9'd0, 16'd0, 1'b1, cyc + 1);
        i_program_end = 1'b1;
        @(negedge i_clock);
        i_program_end = 1'b0;
        repeat (2) @(negedge i_clock);
    endtask

    // Monitor: pop on any DUT activity, then confirm the strobes retire one cycle later.
    initial begin
        logic [1:0] last_st;
        logic last_mode, last_en, settle, settle_en, trig;
        rec_t r;
        last_st = '0; last_mode = 1'b0; last_en = 1'b0; settle = 1'b0; settle_en = 1'b0;
        forever begin
            @(negedge i_clock);
            if (!i_reset) begin
                settle = 1'b0;
            end else begin
                trig = o_pipe_reset | o_instr_we | o_req_valid | o_got_data | o_gib_data |
                       o_error | (o_state != last_st) | (o_mode_step != last_mode) |
                       (o_pipe_enable != last_en);
                if (settle) begin
                    chk("strobes_one_cycle", 64'({o_pipe_reset, o_instr_we, o_req_valid,
                        o_got_data, o_gib_data, o_error}), 64'(0));
                    chk("enable_after", 64'(o_pipe_enable), 64'(settle_en));
                    chk("state_stable", 64'(o_state), 64'(last_st));
                    settle = 1'b0;
                end else if (trig) begin
                    if (q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_event: state=%0d en=%0b err=%0b no response expected (cycle %0d)",
                                 o_state, o_pipe_enable, o_error, cyc);
                    end else begin
                        r = q.pop_front();
                        chk("latency", 64'(cyc), 64'(r.cyc));
                        chk("state", 64'(o_state), 64'(r.st));
                        chk("mode_step", 64'(o_mode_step), 64'(r.mode));
                        chk("pipe_enable", 64'(o_pipe_enable), 64'(r.en));
                        chk("strobes", 64'({o_pipe_reset, o_instr_we, o_req_valid, o_got_data,
                            o_gib_data, o_error}), 64'({r.prst, r.we, r.rv, r.got, r.gib, r.err}));
                        if (r.we) begin
                            chk("instr_addr", 64'(o_instr_addr), 64'(r.ia));
                            chk("instr_data", 64'(o_instr_data), 64'(r.id));
                        end
                        if (r.rv) begin
                            chk("req_type", 64'(o_req_type), 64'(r.rt));
                            chk("req_addr", 64'(o_req_addr), 64'(r.ra));
                        end
                        settle = 1'b1;
                        settle_en = r.en_after;
                    end
                end else if (q.size() > 0 && cyc > q[0].cyc) begin
                    r = q.pop_front();
                    chk("missed_response_cycle", 64'(cyc), 64'(r.cyc));
                end
                if (o_pipe_enable && !last_en) en_rises++;
            end
            last_st = o_state; last_mode = o_mode_step; last_en = o_pipe_enable;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        logic [5:0] c;
        logic [8:0] t;
        repeat (3) @(negedge i_clock);
        chk("reset_outputs", 64'({o_pipe_enable, o_pipe_reset, o_mode_step, o_instr_we,
            o_req_valid, o_got_data, o_gib_data, o_error, o_state}), 64'(0));
        chk("reset_instr_data", 64'(o_instr_data), 64'(0));
        i_reset = 1'b1;
        repeat (2) @(negedge i_clock);

        // Edge detect: held START gives one command
        send(C_START, 9'd0, 16'd0, 3, 1'b0);
        send(C_RESET, 9'd0, 16'd0, 1, 1'b0);

        // Instruction load
        send(C_LSB, 9'd5, 16'h0020, 1, 1'b0);
        send(C_MSB, 9'd5, 16'h2408, 1, 1'b0);
        chk("dir_instr_addr", 64'(o_instr_addr), 64'(5));
        chk("dir_instr_data", 64'(o_instr_data), 64'(32'h24080020));
        send(C_MSB, 9'd6, 16'h1111, 1, 1'b0);

        // Step mode
        send(C_MSTEP, 9'd0, 16'd0, 1, 1'b0);
        send(C_START, 9'd0, 16'd0, 1, 1'b0);
        base = en_rises;
        for (int i = 0; i < 3; i++) send(C_STEP, 9'd0, 16'd0, 2, 1'b0);
        chk("step_pulse_count", 64'(en_rises - base), 64'(3));
        send(C_MCONT, 9'd0, 16'd0, 1, 1'b0);
        chk("mode_kept_in_run", 64'(o_mode_step), 64'(1));
        send(C_STEP, 9'd0, 16'd0, 1, 1'b1);
        send(C_RESET, 9'd0, 16'd0, 1, 1'b0);
        send(C_MCONT, 9'd0, 16'd0, 1, 1'b0);

        // Program end and RESET
        send(C_START, 9'd0, 16'd0, 1, 1'b0);
        pulse_end();
        send(C_START, 9'd0, 16'd0, 1, 1'b0);
        send(C_RESET, 9'd0, 16'd0, 1, 1'b0);
        send(C_START, 9'd0, 16'd0, 1, 1'b0);
        send(C_RESET, 9'd0, 16'd0, 1, 1'b1);

        // Readout handshake
        send(C_REQ, 9'h002, 16'd0, 1, 1'b0);
        send(C_GOT, 9'h010, 16'd1, 3, 1'b0);
        send(C_GIB, 9'h010, 16'd1, 3, 1'b0);
        send(C_MGET, 9'h1FF, 16'hFFFF, 1, 1'b0);
        send(6'b111111, 9'd0, 16'd0, 1, 1'b0);

        // Randomized traffic
        for (int n = 0; n < 160; n++) begin
            t = ($urandom_range(0, 1) == 0) ? 9'd5 : 9'd6;
            case ($urandom_range(0, 13))
                0:  c = C_START;
                1:  c = C_RESET;
                2:  c = C_MCONT;
                3:  c = C_MSTEP;
                4:  c = C_MGET;
                5:  c = C_LSB;
                6:  c = C_MSB;
                7, 8: c = C_STEP;
                9:  begin c = C_REQ; t = 9'($urandom()); end
                10: c = C_GOT;
                11: c = C_GIB;
                12: begin
                    c = 6'($urandom());
                    while (is_legal(c)) c = 6'($urandom());
                end
                default: c = 6'd0;
            endcase
            if (c == 6'd0) pulse_end();
            else send(c, t, 16'($urandom()), int'($urandom_range(1, 3)), 1'b0);
        end

        // Asynchronous reset mid-RUN, released with START valid still high
        send(C_RESET, 9'd0, 16'd0, 1, 1'b0);
        send(C_MCONT, 9'd0, 16'd0, 1, 1'b0);
        send(C_START, 9'd0, 16'd0, 1, 1'b0);
        @(negedge i_clock);
        i_frame_from_blaze = {C_START, 1'b1, 9'd0, 16'd0};
        @(posedge i_clock);
        #2 i_reset = 1'b0;
        #1;
        chk("async_state", 64'(o_state), 64'(S_IDLE));
        chk("async_enable", 64'(o_pipe_enable), 64'(0));
        chk("async_all", 64'({o_pipe_enable, o_pipe_reset, o_mode_step, o_instr_we,
            o_req_valid, o_got_data, o_gib_data, o_error, o_state}), 64'(0));
        model_reset();
        repeat (2) @(negedge i_clock);
        model_apply(1'b1, C_START, 9'd0, 16'd0, 1'b0, cyc + 3);
        i_reset = 1'b1;
        repeat (3) @(negedge i_clock);
        idle_frame();
        repeat (4) @(negedge i_clock);
        chk("async_restart_state", 64'(o_state), 64'(S_RUN));

        repeat (4) @(negedge i_clock);
        chk("queue_drained", 64'(q.size()), 64'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
